// File: rtl/ahsqr_pkg.sv
// Shared types and elaboration helpers for the iterative approximate square-root engine.
package ahsqr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIN  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Bits needed to hold values 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic bit params_ok(input int unsigned w, input int unsigned k);
      return (w >= 4) && (w % 2 == 0) && (k >= 2) && (k % 2 == 0) && (k <= w);
   endfunction

endpackage

// File: rtl/ahsqr_if.sv
// Radicand-in / root-out valid/ready bundle.
interface ahsqr_if #(
   parameter int unsigned WIDTH = 16
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       in_data;
   logic                   in_exact;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH/2-1:0]     out_data;
   logic                   out_exact;

   modport slave (
      input  in_valid, in_data, in_exact, out_ready,
      output in_ready, out_valid, out_data, out_exact
   );

   modport master (
      output in_valid, in_data, in_exact, out_ready,
      input  in_ready, out_valid, out_data, out_exact
   );
endinterface

// File: rtl/ahsqr_lod.sv
// Combinational leading-one detector: index of the highest set bit plus an all-zero flag.
module ahsqr_lod
   import ahsqr_pkg::*;
#(
   parameter  int unsigned W  = 8,
   localparam int unsigned IW = cnt_w(W)
) (
   input  logic [W-1:0]  vec_i,
   output logic [IW-1:0] idx_o,
   output logic          zero_o
);

   // Ascending scan so the highest set bit wins.
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < int'(W); i++) begin
         if (vec_i[i]) idx_o = IW'(i);
      end
   end

   assign zero_o = ~|vec_i;

endmodule

// File: rtl/ahsqr_iter_sqrt.sv
// Multi-cycle floor-sqrt: restoring engine, one root bit per cycle, with an optional
// leading-one "snip" approximation of the low root bits.
module ahsqr_iter_sqrt
   import ahsqr_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned K     = 8
) (
   input  logic    clk,
   input  logic    rst_n,
   ahsqr_if.slave  bus
);

   localparam int unsigned H  = WIDTH / 2;
   localparam int unsigned KH = K / 2;
   localparam int unsigned L  = (WIDTH - K) / 2;
   localparam int unsigned RW = H + 2;
   localparam int unsigned SW = RW + 2;
   localparam int unsigned CW = cnt_w(H + 1);
   localparam int unsigned MW = cnt_w(WIDTH);
   localparam int unsigned IW = cnt_w(KH);
   localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << (WIDTH - K);

   if (!params_ok(WIDTH, K)) begin : g_param_err
      $error("ahsqr_iter_sqrt: illegal WIDTH/K combination");
   end

   state_e           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [H-1:0]     out_data_q, out_data_d;
   logic             out_exact_q, out_exact_d;
   logic             exact_q, exact_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [H-1:0]     root_q, root_d;
   logic [RW-1:0]    rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept_c;
   logic [SW-1:0]    ext_c, sub_c, diff_c;
   logic             neg_c;
   logic [H-1:0]     snip_c;

   assign accept_c = (state_q == IDLE) && bus.in_valid;

   // One restoring step on the operand MSB pair; sign of the difference picks the root bit.
   assign ext_c  = {rem_q, opnd_q[WIDTH-1 -: 2]};
   assign sub_c  = SW'({root_q, 2'b01});
   assign diff_c = ext_c - sub_c;
   assign neg_c  = diff_c[SW-1];

   if (L == 0) begin : g_no_snip
      assign snip_c = root_q;
   end else begin : g_snip
      logic [WIDTH-1:0] num_q;
      logic [IW-1:0]    lod_idx;
      logic             lod_zero;
      logic [MW-1:0]    m_c;
      logic [L-1:0]     frac_c;

      always_ff @(posedge clk) begin
         if (!rst_n)        num_q <= '0;
         else if (accept_c) num_q <= {bus.in_data[WIDTH-1 -: K], 1'b0, bus.in_data[WIDTH-K-1:1]};
      end

      ahsqr_lod #(.W(KH)) u_lod (
         .vec_i  (root_q[KH-1:0]),
         .idx_o  (lod_idx),
         .zero_o (lod_zero)
      );

      assign m_c    = MW'(lod_idx) + MW'(L);
      assign frac_c = lod_zero ? '1 : L'(num_q >> m_c);
      assign snip_c = {root_q[KH-1:0], frac_c};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_exact_q <= 1'b0;
         exact_q     <= 1'b0;
         opnd_q      <= '0;
         root_q      <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_exact_q <= out_exact_d;
         exact_q     <= exact_d;
         opnd_q      <= opnd_d;
         root_q      <= root_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_exact_d = out_exact_q;
      exact_d     = exact_q;
      opnd_d      = opnd_q;
      root_d      = root_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               exact_d = bus.in_exact;
               opnd_d  = bus.in_exact ? bus.in_data : (bus.in_data & HI_MASK);
               root_d  = '0;
               rem_d   = '0;
               cnt_d   = bus.in_exact ? CW'(H) : CW'(KH);
               state_d = ITER;
            end
         end
         ITER: begin
            root_d = {root_q[H-2:0], ~neg_c};
            rem_d  = RW'(neg_c ? ext_c : diff_c);
            opnd_d = opnd_q << 2;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = FIN;
         end
         FIN: begin
            out_valid_d = 1'b1;
            out_data_d  = exact_q ? root_q : snip_c;
            out_exact_d = exact_q;
            state_d     = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d = (state_d == IDLE);
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_exact = out_exact_q;

endmodule
